// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: pulses pll_rst, waits for stable lock, then releases sys_reset_n.
// Define PLL_RESET_SEQUENCER_AUTO_RELOCK_EN to relock on lock loss instead of faulting.
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int LOCK_STABLE   = 1024,
  parameter int UNLOCK_FILTER = 4,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_reset,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);

  localparam int M1   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int M2   = (LOCK_STABLE > UNLOCK_FILTER) ? LOCK_STABLE : UNLOCK_FILTER;
  localparam int MAXP = (M1 > M2) ? M1 : M2;
  localparam int CW   = (MAXP > 2) ? $clog2(MAXP) : 1;

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] UNL_LAST = CW'(UNLOCK_FILTER - 1);
  localparam logic [3:0]    MAX_R    = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAULT  = 3'd4
  } st_e;

  // Output word {pll_rst, sys_reset_n, ready, fault}, registered alongside the state.
  localparam logic [3:0] O_RESET  = 4'b1000;
  localparam logic [3:0] O_WAIT   = 4'b0000;
  localparam logic [3:0] O_STABLE = 4'b0000;
  localparam logic [3:0] O_RUN    = 4'b0110;
  localparam logic [3:0] O_FAULT  = 4'b1001;

  st_e           st;
  logic [3:0]    outs;
  logic [CW-1:0] cnt;
  logic [3:0]    retry;
  logic [1:0]    sync;
  logic          locked_s;

  assign locked_s    = sync[1];
  assign pll_rst     = outs[3];
  assign sys_reset_n = outs[2];
  assign ready       = outs[1];
  assign fault       = outs[0];
  assign retry_cnt   = retry;
  assign state       = st;

  // Lock indication is meaningless while the PLL is held in reset, so the
  // synchronizer is flushed then; lock is only seen 2 cycles after pll_rst drops.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n)       sync <= 2'b00;
    else if (outs[3]) sync <= 2'b00;
    else              sync <= {sync[0], pll_locked};
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= S_RESET;
      outs  <= O_RESET;
      cnt   <= '0;
      retry <= '0;
    end else if (soft_reset) begin
      st    <= S_RESET;
      outs  <= O_RESET;
      cnt   <= '0;
      retry <= '0;
    end else begin
      cnt <= cnt + CW'(1);
      unique case (st)
        S_RESET: begin
          if (cnt == RST_LAST) begin
            st <= S_WAIT; outs <= O_WAIT; cnt <= '0;
          end
        end
        S_WAIT: begin
          if (locked_s) begin
            st <= S_STABLE; outs <= O_STABLE; cnt <= '0;
          end else if (cnt == TO_LAST) begin
            cnt <= '0;
            if (retry == MAX_R) begin
              st <= S_FAULT; outs <= O_FAULT;
            end else begin
              st    <= S_RESET; outs <= O_RESET;
              retry <= (retry == 4'hF) ? retry : retry + 4'd1;
            end
          end
        end
        S_STABLE: begin
          if (!locked_s) begin
            st <= S_WAIT; outs <= O_WAIT; cnt <= '0;
          end else if (cnt == STB_LAST) begin
            st <= S_RUN; outs <= O_RUN; cnt <= '0;
          end
        end
        S_RUN: begin
          // cnt holds the current run of unlocked cycles
          if (locked_s) begin
            cnt <= '0;
          end else if (cnt == UNL_LAST) begin
            cnt <= '0;
`ifdef PLL_RESET_SEQUENCER_AUTO_RELOCK_EN
            st <= S_RESET; outs <= O_RESET; retry <= '0;
`else
            st <= S_FAULT; outs <= O_FAULT;
`endif
          end
        end
        S_FAULT: cnt <= '0;
        default: begin
          st <= S_RESET; outs <= O_RESET; cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomized bench for pll_reset_sequencer against a phase/age-based reference model.
module tb_pll_reset_sequencer;
  localparam int RST_CYCLES = 4, LOCK_TIMEOUT = 32, LOCK_STABLE = 8;
  localparam int UNLOCK_FILTER = 3, MAX_RETRIES = 2;

  logic refclk = 1'b0;
  logic rst_n = 1'b0, pll_locked = 1'b1, soft_reset = 1'b0;
  logic pll_rst, sys_reset_n, ready, fault;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  int n_vec = 0, n_err = 0;

  always #5 refclk = ~refclk;

  pll_reset_sequencer #(
    .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT), .LOCK_STABLE(LOCK_STABLE),
    .UNLOCK_FILTER(UNLOCK_FILTER), .MAX_RETRIES(MAX_RETRIES)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .soft_reset(soft_reset),
    .pll_rst(pll_rst), .sys_reset_n(sys_reset_n), .ready(ready), .fault(fault),
    .retry_cnt(retry_cnt), .state(state)
  );

  // Reference model: phase number, cycles spent in the phase, unlocked run length
  // and a two-deep delay line standing in for the lock synchronizer.
  typedef struct {
    int st; int age; int retry; int unl; bit ls1; bit ls2;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.st = 0; r.age = 0; r.retry = 0; r.unl = 0; r.ls1 = 1'b0; r.ls2 = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mstep(mdl_t c, logic lk, logic sr);
    mdl_t n = c;
    bit ls = c.ls2;
    bit go = 1'b0;
    int to = c.st;
    n.ls2 = c.ls1;
    n.ls1 = (c.st == 0 || c.st == 4) ? 1'b0 : lk;
    n.unl = (c.st == 3 && !ls) ? c.unl + 1 : 0;
    if (sr) begin
      to = 0; go = 1'b1; n.retry = 0;
    end else begin
      case (c.st)
        0: if (c.age + 1 >= RST_CYCLES) begin to = 1; go = 1'b1; end
        1: if (ls) begin to = 2; go = 1'b1; end
           else if (c.age + 1 >= LOCK_TIMEOUT) begin
             go = 1'b1;
             if (c.retry >= MAX_RETRIES) to = 4;
             else begin to = 0; n.retry = (c.retry < 15) ? c.retry + 1 : 15; end
           end
        2: if (!ls) begin to = 1; go = 1'b1; end
           else if (c.age + 1 >= LOCK_STABLE) begin to = 3; go = 1'b1; end
        3: if (n.unl >= UNLOCK_FILTER) begin
             go = 1'b1;
`ifdef PLL_RESET_SEQUENCER_AUTO_RELOCK_EN
             to = 0; n.retry = 0;
`else
             to = 4;
`endif
           end
        default: ;
      endcase
    end
    n.st  = to;
    n.age = go ? 0 : c.age + 1;
    if (go) n.unl = 0;
    return n;
  endfunction

  always @(posedge refclk or negedge rst_n) begin
    if (!rst_n) m <= mdl_reset();
    else        m <= mstep(m, pll_locked, soft_reset);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("state", 32'(state), 32'(m.st));
    chk("pll_rst", 32'(pll_rst), 32'(m.st == 0 || m.st == 4));
    chk("sys_reset_n", 32'(sys_reset_n), 32'(m.st == 3));
    chk("ready", 32'(ready), 32'(m.st == 3));
    chk("fault", 32'(fault), 32'(m.st == 4));
    chk("retry_cnt", 32'(retry_cnt), 32'(m.retry));
  endtask

  task automatic tick(input logic lk, input logic sr);
    @(negedge refclk);
    check_all();
    pll_locked = lk;
    soft_reset = sr;
  endtask

  task automatic areset();
    @(posedge refclk);
    #2 rst_n = 1'b0;
    #1;
    check_all();
    chk("arst_pll_rst", 32'(pll_rst), 32'd1);
    chk("arst_sys_reset_n", 32'(sys_reset_n), 32'd0);
    chk("arst_state", 32'(state), 32'd0);
    @(negedge refclk);
    @(negedge refclk);
    rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    int seg;
    logic lk;

    // Power-up, lock high from the start
    repeat (2) @(posedge refclk);
    #1;
    check_all();
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_retry", 32'(retry_cnt), 32'd0);
    @(negedge refclk);
    rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 1'b0);
      lat++;
      if (ready) break;
    end
    chk("pwrup_latency", 32'(lat), 32'd15);
    repeat (5) tick(1'b1, 1'b0);

    // Short glitch must be filtered
    repeat (2) tick(1'b0, 1'b0);
    repeat (8) tick(1'b1, 1'b0);
    chk("glitch_ready", 32'(ready), 32'd1);

    // Lock loss of UNLOCK_FILTER cycles
    repeat (3) tick(1'b0, 1'b0);
    repeat (4) tick(1'b1, 1'b0);
`ifdef PLL_RESET_SEQUENCER_AUTO_RELOCK_EN
    chk("loss_relock", 32'(sys_reset_n), 32'd0);
`else
    chk("loss_fault", 32'(state), 32'd4);
`endif

    // Lock never arrives: three attempts then sticky FAULT
    tick(1'b0, 1'b1);
    repeat (160) tick(1'b0, 1'b0);
    chk("nolock_state", 32'(state), 32'd4);
    chk("nolock_retry", 32'(retry_cnt), 32'd2);
    chk("nolock_pll_rst", 32'(pll_rst), 32'd1);

    // Soft reset out of FAULT, then an unstable lock in STABLE
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    chk("soft_state", 32'(state), 32'd0);
    chk("soft_fault", 32'(fault), 32'd0);
    repeat (6) tick(1'b0, 1'b0);
    repeat (5) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    repeat (16) tick(1'b1, 1'b0);
    chk("unstable_ready", 32'(ready), 32'd1);

    // Asynchronous reset while in STABLE
    tick(1'b1, 1'b1);
    for (int i = 0; i < 50 && m.st != 2; i++) tick(1'b1, 1'b0);
    chk("reach_stable", 32'(state), 32'd2);
    tick(1'b1, 1'b0);
    areset();

    // Randomized lock behaviour with occasional restarts and resets
    for (int s = 0; s < 150; s++) begin
      lk  = 1'($urandom_range(0, 2) != 0);
      seg = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 40);
      for (int i = 0; i < seg; i++)
        tick(lk, 1'($urandom_range(0, 199) == 0));
      if ($urandom_range(0, 39) == 0) areset();
    end
    tick(1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
